// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges load-unit and ALU results onto the single regfile write port,
// with an ALU starvation guard and forwarding of the in-flight write to rs1/rs2 readers.
module wb_arbiter #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wb_stall,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [4:0]  mem_rd,
    input  logic [31:0] mem_data,
    input  logic        alu_valid,
    output logic        alu_ready,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    output logic        wr_en,
    output logic [4:0]  rd,
    output logic [31:0] wdata,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    output logic        fwd1_hit,
    output logic [31:0] fwd1_data,
    output logic        fwd2_hit,
    output logic [31:0] fwd2_data
);

    localparam int unsigned RW = 5;
    localparam int unsigned DW = 32;
    localparam int unsigned CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    logic [CW-1:0] starve_q, starve_d;
    logic          wr_en_q, wr_en_d;
    logic [RW-1:0] rd_q, rd_d;
    logic [DW-1:0] wdata_q, wdata_d;

    logic          force_alu;
    logic          grant_mem, grant_alu;

    // Grant selection: mem wins ties unless the ALU has waited STARVE_MAX cycles.
    always_comb begin
        force_alu = (starve_q == CW'(STARVE_MAX));
        grant_mem = 1'b0;
        grant_alu = 1'b0;
        if (!wb_stall) begin
            grant_mem = mem_valid && !(alu_valid && force_alu);
            grant_alu = alu_valid && !(mem_valid && !force_alu);
        end
    end

    assign mem_ready = grant_mem;
    assign alu_ready = grant_alu;

    // Next-state: output stage and saturating starvation counter.
    always_comb begin
        starve_d = '0;
        wr_en_d  = 1'b0;
        rd_d     = rd_q;
        wdata_d  = wdata_q;

        if (grant_mem) begin
            rd_d    = mem_rd;
            wdata_d = mem_data;
            wr_en_d = (mem_rd != '0);
        end else if (grant_alu) begin
            rd_d    = alu_rd;
            wdata_d = alu_data;
            wr_en_d = (alu_rd != '0);
        end

        // Stalled cycles with a pending ALU result count as waiting.
        if (alu_valid && !grant_alu) begin
            starve_d = force_alu ? starve_q : starve_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_q <= '0;
            wr_en_q  <= 1'b0;
            rd_q     <= '0;
            wdata_q  <= '0;
        end else begin
            starve_q <= starve_d;
            wr_en_q  <= wr_en_d;
            rd_q     <= rd_d;
            wdata_q  <= wdata_d;
        end
    end

    assign wr_en = wr_en_q;
    assign rd    = rd_q;
    assign wdata = wdata_q;

    // Bypass the write that the regfile has not yet absorbed; x0 never forwards.
    always_comb begin
        fwd1_hit  = wr_en_q && (rd_q == rs1) && (rs1 != '0);
        fwd2_hit  = wr_en_q && (rd_q == rs2) && (rs2 != '0);
        fwd1_data = fwd1_hit ? wdata_q : '0;
        fwd2_data = fwd2_hit ? wdata_q : '0;
    end

endmodule
